// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor, result = a - b over WIDTH cycles.
// Define SERIAL_SUB_SIGNED_EN for two's-complement overflow instead of borrow.
module serial_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic             d_bit;
  logic             borrow_nx;
  logic             ovf_nx;
  logic [WIDTH-1:0] res_nx;

`ifdef SERIAL_SUB_SIGNED_EN
  // Operand sign bits are shifted out of a_sh/b_sh, so keep copies.
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
`endif

  always_comb begin
    d_bit     = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
    borrow_nx = (~a_sh_q[0] & b_sh_q[0])
              | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
    res_nx    = {d_bit, res_sh_q[WIDTH-1:1]};
`ifdef SERIAL_SUB_SIGNED_EN
    ovf_nx    = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
`else
    ovf_nx    = borrow_nx;
`endif
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
`ifdef SERIAL_SUB_SIGNED_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          res_sh_d = '0;
          cnt_d    = '0;
          borrow_d = 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
`endif
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_nx;
        borrow_d = borrow_nx;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          result_d = res_nx;
          ovf_d    = ovf_nx;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
`ifdef SERIAL_SUB_SIGNED_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
`endif
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: vector table, scoreboard queue,
// plus reset-abort, ignored-start and back-to-back sequences.
module tb_serial_subtractor;

  localparam int W = 5;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         overflow;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a_i),
    .b        (b_i),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ovf_u;
    logic         ovf_s;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic pick_ovf(input vec_t v);
`ifdef SERIAL_SUB_SIGNED_EN
    return v.ovf_s;
`else
    return v.ovf_u;
`endif
  endfunction

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, " unexpected done"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({name, " result"}, int'(result), int'(e.res));
      check({name, " overflow"}, int'(overflow), int'(e.ovf));
    end
  endtask

  // One operation; optionally pulses start with junk operands while RUN.
  task automatic run_op(input vec_t v, input bit glitch, input string name);
    int  lat;
    bit  seen;
    int  dones;
    logic [W-1:0] r_hold;
    @(negedge clk);
    a_i = v.a;
    b_i = v.b;
    start = 1'b1;
    sb.push_back('{res: v.res, ovf: pick_ovf(v)});
    @(negedge clk);
    start = 1'b0;
    check({name, " busy"}, int'(busy), 1);
    lat = 1;
    seen = 0;
    while (!seen && lat < 20) begin
      if (glitch && lat == 2) begin
        start = 1'b1;
        a_i = ~v.a;
        b_i = v.a;
      end
      if (glitch && lat == 3) start = 1'b0;
      if (done) begin
        seen = 1;
        check({name, " latency"}, lat, LAT);
        pop_check(name);
      end else begin
        lat++;
        @(negedge clk);
      end
    end
    if (!seen) check({name, " done timeout"}, 0, 1);
    r_hold = result;
    @(negedge clk);
    check({name, " idle after done"}, int'({busy, done}), 0);
    check({name, " result held"}, int'(result), int'(r_hold));
    if (glitch) begin
      dones = 0;
      for (int i = 0; i < 10; i++) begin
        if (done) dones++;
        @(negedge clk);
      end
      check({name, " extra dones"}, dones, 0);
    end
  endtask

  initial begin
    vec_t v;
    int   lat;
    int   got;
    int   dones;

    vecs[0]  = '{a: 5'd9,  b: 5'd3,  res: 5'd6,  ovf_u: 0, ovf_s: 0};
    vecs[1]  = '{a: 5'd3,  b: 5'd9,  res: 5'd26, ovf_u: 1, ovf_s: 0};
    vecs[2]  = '{a: 5'd15, b: 5'd31, res: 5'd16, ovf_u: 1, ovf_s: 1};
    vecs[3]  = '{a: 5'd16, b: 5'd31, res: 5'd17, ovf_u: 1, ovf_s: 0};
    vecs[4]  = '{a: 5'd7,  b: 5'd7,  res: 5'd0,  ovf_u: 0, ovf_s: 0};
    vecs[5]  = '{a: 5'd21, b: 5'd0,  res: 5'd21, ovf_u: 0, ovf_s: 0};
    vecs[6]  = '{a: 5'd0,  b: 5'd1,  res: 5'd31, ovf_u: 1, ovf_s: 0};
    vecs[7]  = '{a: 5'd31, b: 5'd0,  res: 5'd31, ovf_u: 0, ovf_s: 0};
    vecs[8]  = '{a: 5'd16, b: 5'd1,  res: 5'd15, ovf_u: 0, ovf_s: 1};
    vecs[9]  = '{a: 5'd0,  b: 5'd16, res: 5'd16, ovf_u: 1, ovf_s: 1};
    vecs[10] = '{a: 5'd31, b: 5'd31, res: 5'd0,  ovf_u: 0, ovf_s: 0};
    vecs[11] = '{a: 5'd12, b: 5'd5,  res: 5'd7,  ovf_u: 0, ovf_s: 0};

    repeat (3) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset result", int'(result), 0);
    check("reset overflow", int'(overflow), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end

    run_op(vecs[1], 1'b1, "ignored start");

    // Abort: reset at cycle 3 of a run clears everything, no done follows.
    @(negedge clk);
    a_i = 5'd9;
    b_i = 5'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort outputs", int'({busy, done, result, overflow}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("abort no done/busy", dones, 0);
    check("abort result", int'(result), 0);

    // Start held high: second op re-samples a/b in IDLE, period W+2.
    @(negedge clk);
    v = vecs[0];
    a_i = v.a;
    b_i = v.b;
    start = 1'b1;
    sb.push_back('{res: v.res, ovf: pick_ovf(v)});
    @(negedge clk);
    v = vecs[2];
    a_i = v.a;
    b_i = v.b;
    sb.push_back('{res: v.res, ovf: pick_ovf(v)});
    lat = 1;
    got = 0;
    while (got < 2 && lat < 40) begin
      if (done) begin
        got++;
        check($sformatf("b2b done%0d cycle", got), lat, got * (W + 2) - 1);
        pop_check($sformatf("b2b%0d", got));
        if (got == 2) start = 1'b0;
      end
      lat++;
      @(negedge clk);
    end
    if (got < 2) check("b2b done timeout", got, 2);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
